// File: rtl/implode_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : implode_loader_pkg
// Description : Shared types and constants for the implode loader: the
//               4-phase receive FSM state encoding and the default nonce
//               index width.
// Revision    : 1.0 - initial release
// ============================================================================
package implode_loader_pkg;

    // Default width of a nonce index.
    localparam int C_NONCE_WIDTH_DEFAULT = 7;

    // Receive-side 4-phase handshake states.
    typedef enum logic [0:0] {
        WAIT_REQ     = 1'b0,
        WAIT_REQ_LOW = 1'b1
    } hs_state_e;

endpackage : implode_loader_pkg
`default_nettype wire

// File: rtl/implode_loader_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               always presented on o_head while o_empty is low.
//               Pushes while full and pops while empty are ignored.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_push_data - write request and data
//               i_pop           - consume the head entry
//               o_head          - head-of-FIFO data (valid when !o_empty)
//               o_count         - occupancy, 0..2**DEPTH_LOG2
//               o_full/o_empty  - decoded from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH      = 7,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                  C_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH_CNT = (DEPTH_LOG2 + 1)'(C_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem_q [C_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr_q;
    logic [DEPTH_LOG2-1:0] r_rd_ptr_q;
    logic [DEPTH_LOG2:0]   r_count_q;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count_q == C_DEPTH_CNT);
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_head    = r_mem_q[r_rd_ptr_q];

    // Full/empty come from the registered count, so a pop cannot free room
    // for a push in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr_q <= r_wr_ptr_q + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr_q <= r_rd_ptr_q + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count_q <= r_count_q + C_CNT_ONE;
                2'b01:   r_count_q <= r_count_q - C_CNT_ONE;
                default: r_count_q <= r_count_q;
            endcase
        end
    end

    // Storage is intentionally not reset; the count qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_push_data;
        end
    end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/implode_loader.sv
`default_nettype none
// ============================================================================
// Module      : implode_loader
// Description : Accepts nonce indices from the shuffle stage over a 4-phase
//               req/ack handshake, buffers them in a FWFT FIFO and offers
//               them to the implode stage over valid/ready. Ack is withheld
//               while the FIFO is full.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_handshake_req   - 4-phase request from shuffle
//               i_data            - nonce index, stable while req is high
//               o_handshake_ack   - 4-phase acknowledge (registered)
//               o_valid/o_nonce   - head-of-FIFO nonce to implode
//               i_ready           - implode consumes o_nonce this cycle
//               o_count/o_full    - FIFO occupancy and full flag
// Revision    : 1.0 - initial release
// ============================================================================
module implode_loader
    import implode_loader_pkg::*;
#(
    parameter int NONCE_WIDTH = C_NONCE_WIDTH_DEFAULT,
    parameter int DEPTH_LOG2  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_handshake_req,
    input  logic [NONCE_WIDTH-1:0] i_data,
    output logic                   o_handshake_ack,
    output logic                   o_valid,
    output logic [NONCE_WIDTH-1:0] o_nonce,
    input  logic                   i_ready,
    output logic [DEPTH_LOG2:0]    o_count,
    output logic                   o_full
);

    hs_state_e r_state_q;
    hs_state_e w_state_d;
    logic      r_ack_q;
    logic      w_ack_d;
    logic      w_push;
    logic      w_full;
    logic      w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= WAIT_REQ;
            r_ack_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ack_q   <= w_ack_d;
        end
    end

    // One push per 4-phase transaction: the push happens only on the
    // WAIT_REQ -> WAIT_REQ_LOW transition, and the FSM cannot return to
    // WAIT_REQ until the sender has dropped req.
    always_comb begin
        w_state_d = r_state_q;
        w_ack_d   = r_ack_q;
        w_push    = 1'b0;
        case (r_state_q)
            WAIT_REQ: begin
                if (i_handshake_req && !w_full) begin
                    w_push    = 1'b1;
                    w_ack_d   = 1'b1;
                    w_state_d = WAIT_REQ_LOW;
                end
            end
            WAIT_REQ_LOW: begin
                if (!i_handshake_req) begin
                    w_ack_d   = 1'b0;
                    w_state_d = WAIT_REQ;
                end
            end
            default: begin
                w_ack_d   = 1'b0;
                w_state_d = WAIT_REQ;
            end
        endcase
    end

    sync_fifo_fwft #(
        .WIDTH      (NONCE_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (i_data),
        .i_pop       (i_ready),
        .o_head      (o_nonce),
        .o_count     (o_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_handshake_ack = r_ack_q;
    assign o_valid         = !w_empty;
    assign o_full          = w_full;

endmodule : implode_loader
`default_nettype wire
